// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared completion record, requester indices and default widths for the writeback arbiter
package wb_arb_pkg;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_DEPTH   = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_IDX_W   = 4;
  localparam int DEF_EXC_W   = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_MUL = 2;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] result;
    logic [DEF_IDX_W-1:0]  complete_idx;
    logic [DEF_EXC_W-1:0]  exception_vector;
  } completion_t;
endpackage

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: per-requester synchronous FIFO of completion records with flush
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter type T     = completion_t,
  parameter int  DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         data_i,
  output T                         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/wb_completion_arbiter.sv
// wb_completion_arbiter: round-robin merge of ALU/MEM/MUL completions onto one registered ROB port
// Define WB_ARB_BYPASS_EN to let an empty requester's live input win arbitration directly.
module wb_completion_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int EXC_W   = DEF_EXC_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_flush,
  input  logic [NUM_REQ-1:0]         in_valid,
  output logic [NUM_REQ-1:0]         in_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  in_result,
  input  logic [NUM_REQ*IDX_W-1:0]   in_complete_idx,
  input  logic [NUM_REQ*EXC_W-1:0]   in_exception_vector,
  output logic                       out_complete,
  output logic [DATA_W-1:0]          out_result,
  output logic [IDX_W-1:0]           out_complete_idx,
  output logic [EXC_W-1:0]           out_exception_vector,
  output logic [NUM_REQ-1:0]         out_grant
);
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [IDX_W-1:0]  complete_idx;
    logic [EXC_W-1:0]  exception_vector;
  } entry_t;
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  entry_t in_e [NUM_REQ];
  entry_t head [NUM_REQ];
  entry_t src [NUM_REQ];
  entry_t sel;
  logic [CW-1:0] cnt [NUM_REQ];
  logic [NUM_REQ-1:0] full, empty, push, pop, cand, grant, byp;
  logic [PW-1:0] rr_q, rr_d, c;
`ifdef WB_ARB_BYPASS_EN
  assign cand = ~empty | in_valid;
  assign byp  = grant & empty;
`else
  assign cand = ~empty;
  assign byp  = '0;
`endif
  assign pop  = grant & ~empty;
  assign push = in_valid & ~full & ~byp;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign in_e[i] = {in_result[i*DATA_W +: DATA_W], in_complete_idx[i*IDX_W +: IDX_W],
                      in_exception_vector[i*EXC_W +: EXC_W]};
    assign in_ready[i] = cnt[i] < CW'(DEPTH);
`ifdef WB_ARB_BYPASS_EN
    assign src[i] = empty[i] ? in_e[i] : head[i];
`else
    assign src[i] = head[i];
`endif
    wb_arb_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (in_flush),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  (in_e[i]),
      .data_o  (head[i]),
      .count_o (cnt[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end
  // Scan from farthest to nearest so the candidate closest to rr_q wins.
  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    c     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = PW'((int'(rr_q) + k) % NUM_REQ);
      if (cand[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        rr_d     = PW'((int'(rr_q) + k + 1) % NUM_REQ);
      end
    end
  end
  always_comb begin
    sel = src[0];
    for (int k = 0; k < NUM_REQ; k++) sel = grant[k] ? src[k] : sel;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_complete         <= 1'b0;
      out_grant            <= '0;
      out_result           <= '0;
      out_complete_idx     <= '0;
      out_exception_vector <= '0;
      rr_q                 <= '0;
    end else if (in_flush) begin
      out_complete <= 1'b0;
      out_grant    <= '0;
    end else begin
      out_complete <= |grant;
      out_grant    <= grant;
      rr_q         <= rr_d;
      if (|grant) {out_result, out_complete_idx, out_exception_vector} <= sel;
    end
  end
endmodule

// File: tb/tb_wb_completion_arbiter.sv
// tb_wb_completion_arbiter: vector table plus hand sequences, with per-requester scoreboard queues
module tb_wb_completion_arbiter;
  import wb_arb_pkg::*;
`ifdef WB_ARB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic reset, in_flush;
  logic [2:0] in_valid, in_ready, out_grant;
  logic [95:0] in_result;
  logic [11:0] in_complete_idx;
  logic [8:0] in_exception_vector;
  logic out_complete;
  logic [31:0] out_result;
  logic [3:0] out_complete_idx;
  logic [2:0] out_exception_vector;
  typedef struct packed {logic [31:0] r; logic [3:0] x; logic [2:0] e;} ent_t;
  typedef struct {
    logic [2:0] v;
    logic [2:0][31:0] r;
    logic [2:0][3:0] x;
    logic [2:0][2:0] e;
    logic [8:0] gs;
  } vec_t;
  ent_t q [3][$];
  vec_t vt [8];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb_completion_arbiter dut (
    .clk(clk), .reset(reset), .in_flush(in_flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_complete_idx(in_complete_idx), .in_exception_vector(in_exception_vector),
    .out_complete(out_complete), .out_result(out_result), .out_complete_idx(out_complete_idx),
    .out_exception_vector(out_exception_vector), .out_grant(out_grant)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic set_in(input int i, input logic [31:0] r, input logic [3:0] x, input logic [2:0] e);
    in_valid[i] = 1'b1;
    in_result[i*32 +: 32] = r;
    in_complete_idx[i*4 +: 4] = x;
    in_exception_vector[i*3 +: 3] = e;
  endtask
  task automatic tick();
    chk("protocol", 64'(in_valid & ~in_ready), 0);
    for (int i = 0; i < 3; i++)
      if (reset || in_flush) q[i].delete();
      else if (in_valid[i] && in_ready[i])
        q[i].push_back({in_result[i*32 +: 32], in_complete_idx[i*4 +: 4], in_exception_vector[i*3 +: 3]});
    @(posedge clk);
    #1;
    if (out_complete) begin
      chk("grant_onehot", 64'($onehot(out_grant)), 1);
      for (int i = 0; i < 3; i++)
        if (out_grant[i]) begin
          chk("expected_entry", 64'(q[i].size() != 0), 1);
          if (q[i].size() != 0) chk("out_data", {out_result, out_complete_idx, out_exception_vector}, q[i].pop_front());
        end
    end else chk("idle_grant", 64'(out_grant), 0);
  endtask
  initial begin
    int lat, g, k, cnt;
    logic [8:0] gs;
    logic saw_full;
    vt[0] = '{3'b100, {32'h30, 32'h0, 32'h0}, {4'd5, 4'd0, 4'd0}, {3'd0, 3'd0, 3'd0}, 9'b000_000_100};
    vt[1] = '{3'b111, {32'h300, 32'h200, 32'h100}, {4'd3, 4'd2, 4'd1}, {3'd0, 3'd0, 3'd0}, 9'b001_010_100};
    vt[2] = '{3'b010, {32'h0, 32'h900, 32'h0}, {4'd0, 4'd9, 4'd0}, {3'd0, 3'b010, 3'd0}, 9'b000_000_010};
    vt[3] = '{3'b101, {32'h700, 32'h0, 32'h600}, {4'd7, 4'd0, 4'd6}, {3'd1, 3'd0, 3'd4}, 9'b000_100_001};
    vt[4] = '{3'b011, {32'h0, 32'hB00, 32'hA00}, {4'd0, 4'd11, 4'd10}, {3'd0, 3'd7, 3'd2}, 9'b000_010_001};
    vt[5] = '{3'b111, {32'hE00, 32'hD00, 32'hC00}, {4'd14, 4'd13, 4'd12}, {3'd3, 3'd5, 3'd6}, 9'b010_100_001};
    vt[6] = '{3'b000, {32'h1, 32'h2, 32'h3}, {4'd1, 4'd2, 4'd3}, {3'd1, 3'd1, 3'd1}, 9'b000_000_000};
    vt[7] = '{3'b001, {32'h0, 32'h0, 32'hF00}, {4'd0, 4'd0, 4'd15}, {3'd0, 3'd0, 3'd0}, 9'b000_000_001};
    reset = 1'b1; in_flush = 1'b0; in_valid = '0;
    in_result = '0; in_complete_idx = '0; in_exception_vector = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_complete", 64'(out_complete), 0);
    chk("rst_grant", 64'(out_grant), 0);
    chk("rst_result", 64'(out_result), 0);
    chk("rst_idx", 64'(out_complete_idx), 0);
    chk("rst_exc", 64'(out_exception_vector), 0);
    chk("rst_ready", 64'(in_ready), 3'b111);
    for (int n = 0; n < 8; n++) begin
      in_valid = vt[n].v; in_result = vt[n].r; in_complete_idx = vt[n].x; in_exception_vector = vt[n].e;
      gs = '0; g = 0; lat = 0;
      for (int t = 1; t <= 6; t++) begin
        tick();
        if (t == 1) in_valid = '0;
        if (out_complete) begin
          if (lat == 0) lat = t;
          if (g < 3) begin gs = {gs[5:0], out_grant}; g++; end
        end
      end
      chk($sformatf("v%0d_grant_seq", n), 64'(gs), 64'(vt[n].gs));
      chk($sformatf("v%0d_latency", n), 64'(lat), vt[n].v != 0 ? 64'(LAT) : 64'(0));
      if (n == 2) begin
        chk("mem_exc_idx", 64'(out_complete_idx), 9);
        chk("mem_exc_vec", 64'(out_exception_vector), 3'b010);
      end
    end
    saw_full = 1'b0; k = 0;
    for (int t = 0; t < 8; t++) begin
      in_valid = '0;
      if (in_ready[REQ_ALU]) set_in(REQ_ALU, 32'hA000 + t, 4'(t), 3'd0);
      if (in_ready[REQ_MUL] && k < 4) begin set_in(REQ_MUL, 32'hC000 + k, 4'(8 + k), 3'(k)); k++; end
      if (!in_ready[REQ_MUL]) saw_full = 1'b1;
      tick();
    end
    in_valid = '0;
    repeat (10) tick();
    chk("mul_backpressure", 64'(saw_full), 1);
    chk("mul_all_sent", 64'(k), 4);
    chk("sb_drained", 64'(q[0].size() + q[1].size() + q[2].size()), 0);
    for (int t = 0; t < 2; t++) begin
      in_valid = in_ready;
      for (int i = 0; i < 3; i++) if (in_ready[i]) set_in(i, 32'hF100 + 16 * t + i, 4'(i + 4 * t), 3'd1);
      tick();
    end
    in_flush = 1'b1; in_valid = in_ready;
    tick();
    in_flush = 1'b0; in_valid = '0;
    chk("flush_complete", 64'(out_complete), 0);
    chk("flush_grant", 64'(out_grant), 0);
    chk("flush_ready", 64'(in_ready), 3'b111);
    cnt = 0;
    for (int t = 0; t < 6; t++) begin tick(); cnt += int'(out_complete); end
    chk("flush_no_stale", 64'(cnt), 0);
    for (int i = 0; i < 3; i++) set_in(i, 32'h5500 + i, 4'(12 + i), 3'd2);
    tick();
    in_valid = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_complete", 64'(out_complete), 0);
    chk("mid_rst_grant", 64'(out_grant), 0);
    chk("mid_rst_data", {out_result, out_complete_idx, out_exception_vector}, 0);
    chk("mid_rst_ready", 64'(in_ready), 3'b111);
    cnt = 0;
    for (int t = 0; t < 5; t++) begin tick(); cnt += int'(out_complete); end
    chk("mid_rst_no_stale", 64'(cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
